if_stage: RTL
=============

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage, directly upstream of id_stage. Owns the PC, drives the
//  instruction-memory req/gnt/rvalid port, buffers returned words in a small
//  prefetch FIFO and holds the IF-ID pipeline register (instr_rdata/instr_addr to ID).
//  Redirected by EX on taken jumps/branches; held by ID on stall.
// PARAMETERS
//  BOOT_ADDR   32'h0000_0000  PC value after reset
//  FIFO_DEPTH  2              prefetch entries; also the max outstanding+buffered words (2..4)
// PORTS
//  clk_i             in   1   clock, rising edge
//  rst_i             in   1   synchronous reset, active-high
//  instr_req_o       out  1   fetch request to instruction memory
//  instr_addr_o      out  32  fetch address (word aligned)
//  instr_gnt_i       in   1   request accepted this cycle
//  instr_rvalid_i    in   1   response valid (in order, >=1 cycle after gnt)
//  instr_rdata_i     in   32  response data
//  stall_i           in   1   ID not accepting; hold IF-ID register
//  jump_en_i         in   1   EX redirect strobe
//  jump_addr_i       in   32  redirect target; bits[1:0] ignored (forced 0)
//  instr_rdata_id_o  out  32  IF-ID reg: instruction to ID
//  instr_addr_id_o   out  32  IF-ID reg: PC of that instruction
//  instr_valid_id_o  out  1   IF-ID reg holds a real instruction
//  perf_fetch_o      out  32  retired-fetch count (IF_PERF_CNT_EN only)
//  perf_stall_o      out  32  stall-cycle count   (IF_PERF_CNT_EN only)
// BEHAVIOUR
//  - Reset (rst_i=1 at edge): pc_q=BOOT_ADDR, FIFO empty, outstanding=0, discard=0,
//    instr_rdata_id_o=32'h0000_0013 (NOP), instr_addr_id_o=0, instr_valid_id_o=0,
//    perf counters=0. instr_req_o=0 while rst_i=1 (combinational).
//  - instr_addr_o=pc_q. instr_req_o = !rst_i & !jump_en_i & (fifo_cnt+outstanding < FIFO_DEPTH).
//  - req&gnt: pc_q+=4 (32-bit wrap 0xFFFF_FFFC->0), outstanding+1. Request may be withdrawn
//    only on redirect; otherwise req/addr are stable until gnt.
//  - rvalid: outstanding-1. If discard>0: drop word, discard-1. Else: when FIFO empty and
//    IF-ID loads this cycle, word bypasses straight into IF-ID; otherwise pushed to FIFO
//    with its PC (tracked by a separate response-PC counter, +4 per accepted word).
//  - Latency: gnt@t, rvalid@t+1 -> instr_valid_id_o=1 @t+2 (no stall, FIFO empty).
//  - IF-ID load when !stall_i: head of FIFO (pop) or bypassed word, valid=1; if none
//    available, load NOP, valid=0 (bubble). stall_i=1: all IF-ID outputs held, no pop;
//    pushes continue until FIFO full, then req drops.
//  - Full FIFO + rvalid cannot occur (req gating). Push and pop in same cycle allowed.
//  - jump_en_i (priority over stall_i and everything else): pc_q<=jump_addr_i&~3,
//    response-PC<=same, FIFO flushed, IF-ID<=NOP/valid=0, discard<=outstanding after
//    this cycle's rvalid (rvalid in jump cycle is dropped), no request this cycle.
//  - Back-to-back jumps: each re-targets; discard accumulates correctly.
//  - No internal FSM beyond counters; "state" = {fifo_cnt, outstanding, discard}.
// CONFIGURATION
//  IF_PERF_CNT_EN defined: perf_fetch_o counts IF-ID loads with valid=1; perf_stall_o
//   counts cycles with stall_i=1 & !jump_en_i; both wrap at 2^32, cleared by reset.
//  Not defined: counters not built, perf_fetch_o/perf_stall_o tied to 0.
// TESTING
//  1 Reset, BOOT_ADDR=0x80, gnt=1, rvalid 1 cycle later -> first req addr 0x80; IF-ID
//    shows 0x80,0x84,0x88 on consecutive cycles, valid=1 from 2 cycles after first gnt.
//  2 Stall 4 cycles mid-stream -> IF-ID held, FIFO fills to 2, req=0; release -> next
//    addresses continue gap-free, no duplicates, no loss.
//  3 Memory gnt=0 for 3 cycles -> req/addr stable; IF-ID bubbles (valid=0, NOP).
//  4 Jump to 0x1002 with 2 outstanding -> both late responses dropped; next valid IF-ID
//    addr=0x1000; no valid during flush cycle.
//  5 jump_en_i & stall_i same cycle -> jump wins: IF-ID=NOP/valid=0, next req addr=target.
//  6 PC at 0xFFFF_FFFC fetches -> next req 0x0000_0000; with IF_PERF_CNT_EN, 10 fetches +
//    3 stalls -> perf_fetch_o=10, perf_stall_o=3; without macro both 0.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: owns the PC, the instruction-memory port, a prefetch FIFO and the IF-ID register.
// Optional feature macro IF_PERF_CNT_EN builds the fetch/stall performance counters.
module if_stage #(
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        stall_i,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    output logic [31:0] instr_rdata_id_o,
    output logic [31:0] instr_addr_id_o,
    output logic        instr_valid_id_o,
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_stall_o
);
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [3:0]  DEPTH = 4'(FIFO_DEPTH);
    localparam logic [1:0]  LAST  = 2'(FIFO_DEPTH - 1);

    logic [31:0] r_pc;
    logic [31:0] r_rsp_pc;
    logic [31:0] r_fifo_data [4];
    logic [31:0] r_fifo_addr [4];
    logic [1:0]  r_rd_ptr;
    logic [1:0]  r_wr_ptr;
    logic [2:0]  r_fifo_cnt;
    logic [2:0]  r_outstanding;
    logic [2:0]  r_discard;
    logic [31:0] r_id_data;
    logic [31:0] r_id_addr;
    logic        r_id_valid;

    logic [3:0]  w_inflight;
    logic        w_req;
    logic        w_fire;
    logic        w_rsp;
    logic        w_load;
    logic        w_pop;
    logic        w_bypass;
    logic        w_push;
    logic [31:0] w_jump_pc;
    logic [2:0]  w_out_after;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == LAST) ? 2'd0 : p + 2'd1;
    endfunction

    // Buffered plus in-flight words never exceed the FIFO, so rvalid always has room.
    assign w_inflight  = {1'b0, r_fifo_cnt} + {1'b0, r_outstanding};
    assign w_req       = !rst_i && !jump_en_i && (w_inflight < DEPTH);
    assign w_fire      = w_req && instr_gnt_i;
    assign w_rsp       = instr_rvalid_i && !jump_en_i && (r_discard == 3'd0);
    assign w_load      = !stall_i && !jump_en_i;
    assign w_pop       = w_load && (r_fifo_cnt != 3'd0);
    assign w_bypass    = w_load && (r_fifo_cnt == 3'd0) && w_rsp;
    assign w_push      = w_rsp && !w_bypass;
    assign w_jump_pc   = {jump_addr_i[31:2], 2'b00};
    assign w_out_after = r_outstanding - {2'b00, instr_rvalid_i};

    assign instr_req_o      = w_req;
    assign instr_addr_o     = r_pc;
    assign instr_rdata_id_o = r_id_data;
    assign instr_addr_id_o  = r_id_addr;
    assign instr_valid_id_o = r_id_valid;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc          <= BOOT_ADDR;
            r_rsp_pc      <= BOOT_ADDR;
            r_rd_ptr      <= 2'd0;
            r_wr_ptr      <= 2'd0;
            r_fifo_cnt    <= 3'd0;
            r_outstanding <= 3'd0;
            r_discard     <= 3'd0;
            r_id_data     <= NOP;
            r_id_addr     <= 32'h0;
            r_id_valid    <= 1'b0;
        end else if (jump_en_i) begin
            // Every word still in flight after this cycle belongs to the old path.
            r_pc          <= w_jump_pc;
            r_rsp_pc      <= w_jump_pc;
            r_rd_ptr      <= 2'd0;
            r_wr_ptr      <= 2'd0;
            r_fifo_cnt    <= 3'd0;
            r_outstanding <= w_out_after;
            r_discard     <= w_out_after;
            r_id_data     <= NOP;
            r_id_valid    <= 1'b0;
        end else begin
            if (w_fire) begin
                r_pc <= r_pc + 32'd4;
            end
            if (w_rsp) begin
                r_rsp_pc <= r_rsp_pc + 32'd4;
            end
            r_outstanding <= r_outstanding + {2'b00, w_fire}
                           - {2'b00, instr_rvalid_i};
            if (instr_rvalid_i && (r_discard != 3'd0)) begin
                r_discard <= r_discard - 3'd1;
            end
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_fifo_cnt <= r_fifo_cnt + {2'b00, w_push} - {2'b00, w_pop};
            if (w_load) begin
                if (w_pop) begin
                    r_id_data  <= r_fifo_data[r_rd_ptr];
                    r_id_addr  <= r_fifo_addr[r_rd_ptr];
                    r_id_valid <= 1'b1;
                end else if (w_bypass) begin
                    r_id_data  <= instr_rdata_i;
                    r_id_addr  <= r_rsp_pc;
                    r_id_valid <= 1'b1;
                end else begin
                    r_id_data  <= NOP;
                    r_id_valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= instr_rdata_i;
            r_fifo_addr[r_wr_ptr] <= r_rsp_pc;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_perf_fetch <= 32'h0;
            r_perf_stall <= 32'h0;
        end else begin
            if (w_pop || w_bypass) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (stall_i && !jump_en_i) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetch_o = r_perf_fetch;
    assign perf_stall_o = r_perf_stall;
`else
    assign perf_fetch_o = 32'h0;
    assign perf_stall_o = 32'h0;
`endif

endmodule
